spi_channel_writer: RTL and testbench
=====================================

// Module: spi_channel_writer
// PURPOSE
//  Radio channel-change engine, downstream of the SPI control FSM. When Ch_en is
//  asserted it latches Channel (0..15 = IEEE 802.15.4 ch 11..26) and computes FREQ.
//  It writes FSCTRL over SPI, issues the SRXON strobe, then pulses ChannelChange_done.
//  Owns the CC2420 SPI pins only while Busy=1; the FSM arbitrates the bus.
// PARAMETERS
//  CLK_DIV      4      Clock cycles per SCLK half-period (>=2)
//  FSCTRL_ADDR  6'h18  FSCTRL register address
//  LOCK_THR     2'b01  FSCTRL[15:14] lock threshold field
//  SRXON_CMD    8'h03  command strobe sent after the register write
// PORTS
//  Clock               in   1  system clock
//  Reset               in   1  asynchronous, active-low reset
//  Ch_en               in   1  level request from control FSM; start when high in IDLE
//  Channel             in   4  channel index, sampled on the start cycle only
//  MISO                in   1  SPI data from radio
//  SCLK                out  1  SPI clock, mode 0 (idles low)
//  MOSI                out  1  SPI data to radio, MSB first
//  CSn                 out  1  SPI chip select, active low
//  Busy                out  1  high from start cycle until return to IDLE
//  ChannelChange_done  out  1  one-cycle done pulse
//  Status              out  8  radio status byte from the latest transaction's first byte
// BEHAVIOUR
//  Reset (Reset=0, async): SCLK=0, MOSI=0, CSn=1, Busy=0, ChannelChange_done=0,
//   Status=8'h00, state=IDLE. Asserting Reset mid-transfer aborts immediately.
//   No done pulse is produced after an aborted transfer.
//  Data: FREQ[9:0] = 357 + 5*Channel (range 357..432, no overflow).
//   word = {LOCK_THR, 4'b0000, FREQ}.
//   Frame 1: 24 bits = {2'b00, FSCTRL_ADDR}, word[15:8], word[7:0].
//   Frame 2: 8 bits = SRXON_CMD.
//  SPI timing: MOSI changes while SCLK is low; MISO is sampled on SCLK rising edge.
//   Each bit lasts 2*CLK_DIV cycles (low half first, then high half).
//   Status takes the 8 MISO bits of each frame's first byte, updated at frame end.
//  FSM states:
//   IDLE: Ch_en=1 -> latch Channel, Busy=1, CSn=0, go to SETUP1.
//   SETUP1: CLK_DIV cycles, MOSI = bit 23 -> SHIFT1.
//   SHIFT1: 24 bits (48*CLK_DIV cycles, ends with SCLK low) -> CSn=1, go to GAP.
//   GAP: CSn high for 2*CLK_DIV cycles -> CSn=0, go to SETUP2.
//   SETUP2: CLK_DIV cycles -> SHIFT2.
//   SHIFT2: 8 bits (16*CLK_DIV cycles) -> CSn=1, go to DONE.
//   DONE: ChannelChange_done=1 for exactly one cycle -> WAIT_REL.
//   WAIT_REL: stay while Ch_en=1; Ch_en=0 -> IDLE and Busy=0.
//  Latency: done pulse occurs 68*CLK_DIV+1 cycles after the start cycle (273 @ CLK_DIV=4).
//  Channel changes while Busy are ignored (the latched value is used).
//  Ch_en drop mid-transfer does not abort; the transfer completes and the pulse still fires.
//  A level-high Ch_en never retriggers; a new request needs a 0 then 1 seen in IDLE.
//  Outside Busy: CSn=1, SCLK=0, MOSI=0.
// TESTING
//  1. Channel=4'b1001, Ch_en=1 -> MOSI bytes 0x18,0x41,0x92, CSn high for 8 cycles,
//     then 0x03; done pulse at cycle 273.
//  2. Channel=0 -> bytes 0x18,0x41,0x65;
//     Channel=15 -> bytes 0x18,0x41,0xB0 (FREQ boundaries 357/432).
//  3. MISO drives 0x5A in frame 1 and 0x42 in frame 2 ->
//     Status=0x5A after frame 1, 0x42 after frame 2.
//  4. Channel changed to 3 at cycle 20 of a channel-9 transfer -> still 0x4192.
//     Ch_en held high 50 cycles after done -> no second transfer, Busy drops when Ch_en=0.
//  5. Reset=0 at cycle 100 -> CSn=1, SCLK=0 the same cycle, no done pulse.
//     After release a new Ch_en runs a full, correct transfer.
//  6. SPI mode-0 checker on every run: MOSI stable while SCLK high,
//     CSn low exactly 24 and then 8 SCLK rising edges.

Source files
------------

// File: rtl/spi_channel_writer.sv
// -----------------------------------------------------------------------------
// spi_channel_writer
//
// Radio channel-change engine. When a request arrives in IDLE it latches the
// channel index, builds the FSCTRL word (FREQ = 357 + 5*channel), writes it to
// the radio over SPI mode 0, sends the SRXON command strobe, and then pulses
// o_channel_change_done for one cycle. The SPI pins carry meaningful values
// only while o_busy is high; the upstream control FSM arbitrates the bus.
//
// Ports
//   i_clk                  system clock
//   i_rst_n                asynchronous active-low reset (aborts any transfer)
//   i_ch_en                level request; starts a transfer when seen in IDLE
//   i_channel[3:0]         channel index 0..15 (802.15.4 ch 11..26)
//   i_miso                 SPI data from the radio
//   o_sclk                 SPI clock, mode 0 (idles low)
//   o_mosi                 SPI data to the radio, MSB first
//   o_csn                  SPI chip select, active low
//   o_busy                 high from the start cycle until back in IDLE
//   o_channel_change_done  one-cycle completion pulse
//   o_status[7:0]          radio status byte (first byte of the latest frame)
// -----------------------------------------------------------------------------
module spi_channel_writer #(
   parameter int         CLK_DIV     = 4,
   parameter logic [5:0] FSCTRL_ADDR = 6'h18,
   parameter logic [1:0] LOCK_THR    = 2'b01,
   parameter logic [7:0] SRXON_CMD   = 8'h03
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ch_en,
   input  logic [3:0] i_channel,
   input  logic       i_miso,
   output logic       o_sclk,
   output logic       o_mosi,
   output logic       o_csn,
   output logic       o_busy,
   output logic       o_channel_change_done,
   output logic [7:0] o_status
);

   // Counter wide enough to hold 2*CLK_DIV-1 (the gap length)
   localparam int            CW        = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP1,
      S_SHIFT1,
      S_GAP,
      S_SETUP2,
      S_SHIFT2,
      S_DONE,
      S_WAIT_REL
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [5:0]    r_half;     // half-period index inside a SHIFT state
   logic [23:0]   r_shift;    // MSB drives MOSI directly
   logic [7:0]    r_rx;
   logic          r_sclk;
   logic          r_csn;
   logic          r_busy;
   logic          r_done;
   logic [7:0]    r_status;

   logic [9:0]    w_freq;
   logic [23:0]   w_frame1;
   logic          w_half_end;
   logic          w_last_half;
   logic          w_sample_next;

   assign w_freq     = 10'd357 + 10'd5 * {6'd0, i_channel};
   assign w_frame1   = {2'b00, FSCTRL_ADDR, LOCK_THR, 4'b0000, w_freq};
   assign w_half_end = (r_cnt == HALF_LAST);

   // SHIFT halves alternate high (even index) / low (odd index); the frame
   // ends after the trailing low half of its last bit.
   assign w_last_half = (r_state == S_SHIFT1) ? (r_half == 6'd47) : (r_half == 6'd15);

   // Only the first byte of each frame is captured. The rising edge after odd
   // half h starts bit (h+1)/2, so bits 1..7 come from h <= 13.
   assign w_sample_next = (r_half < 6'd15);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_half   <= '0;
         r_shift  <= '0;
         r_rx     <= '0;
         r_sclk   <= 1'b0;
         r_csn    <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_status <= 8'h00;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (i_ch_en) begin
                  // Loading the frame here latches the channel and puts bit 23
                  // on MOSI as chip select falls.
                  r_shift <= w_frame1;
                  r_csn   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP1;
               end
            end

            S_SETUP1, S_SETUP2: begin
               if (w_half_end) begin
                  r_cnt   <= '0;
                  r_half  <= '0;
                  r_sclk  <= 1'b1;
                  r_rx    <= {r_rx[6:0], i_miso};  // first rising edge of frame
                  r_state <= (r_state == S_SETUP1) ? S_SHIFT1 : S_SHIFT2;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_SHIFT1, S_SHIFT2: begin
               if (w_half_end) begin
                  r_cnt  <= '0;
                  r_half <= r_half + 6'd1;
                  if (!r_half[0]) begin
                     // End of high half: fall SCLK and present the next bit
                     r_sclk  <= 1'b0;
                     r_shift <= {r_shift[22:0], 1'b0};
                  end else if (w_last_half) begin
                     r_csn    <= 1'b1;
                     r_status <= r_rx;
                     r_state  <= (r_state == S_SHIFT1) ? S_GAP : S_DONE;
                  end else begin
                     r_sclk <= 1'b1;
                     if (w_sample_next) begin
                        r_rx <= {r_rx[6:0], i_miso};
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_csn   <= 1'b0;
                  r_shift <= {SRXON_CMD, 16'h0000};
                  r_state <= S_SETUP2;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end

            S_DONE: begin
               r_done  <= 1'b1;
               r_state <= S_WAIT_REL;
            end

            S_WAIT_REL: begin
               // A held request must drop before another transfer can start
               if (!i_ch_en) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_sclk                = r_sclk;
   assign o_mosi                = r_shift[23];
   assign o_csn                 = r_csn;
   assign o_busy                = r_busy;
   assign o_channel_change_done = r_done;
   assign o_status              = r_status;

endmodule

// File: tb/tb_spi_channel_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_channel_writer
//
// Self-checking bench for spi_channel_writer. A timing model derived from the
// transfer schedule (offsets from the start cycle) predicts every output on
// every cycle; a bus monitor decodes frames, checks SPI mode-0 rules and acts
// as the radio on MISO. Directed transactions pin the model with literal
// values, then randomized transactions exercise the rest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_channel_writer;

   localparam int D      = 4;
   localparam int DONE_K = 68 * D + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ch_en = 1'b0;
   logic [3:0] channel = 4'd0;
   logic       miso = 1'b0;
   logic       sclk, mosi, csn, busy, done;
   logic [7:0] status;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spi_channel_writer #(
      .CLK_DIV     (D),
      .FSCTRL_ADDR (6'h18),
      .LOCK_THR    (2'b01),
      .SRXON_CMD   (8'h03)
   ) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_ch_en               (ch_en),
      .i_channel             (channel),
      .i_miso                (miso),
      .o_sclk                (sclk),
      .o_mosi                (mosi),
      .o_csn                 (csn),
      .o_busy                (busy),
      .o_channel_change_done (done),
      .o_status              (status)
   );

   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] exp_frame1(input logic [3:0] ch);
      int freq;
      freq = 357 + 5 * int'(ch);
      return {2'b00, 6'h18, 2'b01, 4'b0000, freq[9:0]};
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_busy = 0;
   int          m_k = 0;
   int          m_t0 = 0;
   logic [23:0] m_f1 = '0;
   logic [7:0]  m_f2 = 8'h03;
   logic [7:0]  m_b1 = '0, m_b2 = '0;
   logic [7:0]  m_stat = 8'h00;
   logic [7:0]  miso_b1 = '0, miso_b2 = '0;

   always @(posedge clk or negedge rst_n) begin : model
      if (!rst_n) begin
         m_busy = 0;
         m_k    = 0;
         m_stat = 8'h00;
      end else begin
         cyc++;
         if (!m_busy) begin
            if (ch_en) begin
               m_busy = 1;
               m_k    = 0;
               m_t0   = cyc;
               m_f1   = exp_frame1(channel);
               m_b1   = miso_b1;
               m_b2   = miso_b2;
            end
         end else begin
            m_k++;
            if (m_k == 49 * D) m_stat = m_b1;
            if (m_k == 68 * D) m_stat = m_b2;
            if (m_k >= 68 * D + 2 && !ch_en) m_busy = 0;
         end
      end
   end

   // Compare every cycle, half a clock away from the active edge
   always @(negedge clk) begin : compare
      logic e_csn, e_sclk, e_mosi;
      bit   mv;
      int   k;
      if (rst_n) begin
         k     = m_k;
         e_csn = !(m_busy && (k < 49 * D || (k >= 51 * D && k < 68 * D)));
         e_sclk = m_busy &&
                  ((k >= D && k < 49 * D && ((k - D) / D) % 2 == 0) ||
                   (k >= 52 * D && k < 68 * D && ((k - 52 * D) / D) % 2 == 0));
         mv     = 1;
         e_mosi = 1'b0;
         if (!m_busy)                        e_mosi = 1'b0;
         else if (k < 48 * D)                e_mosi = m_f1[23 - k / (2 * D)];
         else if (k >= 51 * D && k < 67 * D) e_mosi = m_f2[7 - (k - 51 * D) / (2 * D)];
         else                                mv = 0;
         chk("busy", busy, m_busy);
         chk("csn", csn, e_csn);
         chk("sclk", sclk, e_sclk);
         if (mv) chk("mosi", mosi, e_mosi);
         chk("done", done, (m_busy && k == DONE_K));
         chk("status", status, m_stat);
      end
   end

   // ---------------- bus monitor + radio MISO ----------------
   logic        p_sclk = 0, p_csn = 1, p_mosi = 0;
   int          bits = 0, fidx = 0, gap = 0, last_gap = 0;
   logic [31:0] val = '0;
   int          done_cnt = 0, done_cyc = 0;
   logic [31:0] fq_val[$];
   int          fq_len[$];

   always @(negedge clk) begin : monitor
      logic [7:0] b;
      if (!rst_n) begin
         p_sclk = 0; p_csn = 1; p_mosi = 0;
         bits = 0; val = '0; fidx = 0; gap = 0;
      end else begin
         if (p_sclk && sclk) chk("mode0_mosi_stable", mosi, p_mosi);
         if (p_csn && !csn) begin
            if (fidx == 1) last_gap = gap;
            bits = 0;
            val  = '0;
         end
         if (!csn && !p_sclk && sclk) begin
            val = {val[30:0], mosi};
            bits++;
         end
         if (!p_csn && csn) begin
            chk("mode0_edges", bits, (fidx == 0) ? 24 : 8);
            fq_val.push_back(val);
            fq_len.push_back(bits);
            fidx++;
            gap = 0;
         end
         if (csn && busy) gap++;
         if (!busy) fidx = 0;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (!csn && bits < 8) begin
            b    = (fidx == 0) ? miso_b1 : miso_b2;
            miso = b[7 - bits];
         end else begin
            miso = 1'($urandom);
         end
         p_sclk = sclk; p_csn = csn; p_mosi = mosi;
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_txn(input logic [3:0] ch, input logic [7:0] m1, input logic [7:0] m2,
                          input int drop_at, input int chg_at, input int hold_after,
                          input bit lit_en, input logic [23:0] lit_f1);
      int d0;
      bit got;
      logic [23:0] ef1;
      ef1 = exp_frame1(ch);
      fq_val.delete();
      fq_len.delete();
      @(negedge clk);
      miso_b1 = m1;
      miso_b2 = m2;
      channel = ch;
      ch_en   = 1'b1;
      d0      = done_cnt;
      got     = 0;
      for (int i = 1; i <= DONE_K + 20 && !got; i++) begin
         @(negedge clk);
         #1;
         if (i == drop_at) ch_en = 1'b0;
         if (i == chg_at) channel = channel ^ 4'hA;
         if (lit_en && i == 50 * D) chk("status_frame1", status, m1);
         if (done) got = 1;
      end
      chk("done_seen", got, 1);
      if (lit_en) begin
         chk("latency", done_cyc - m_t0, 273);
         chk("gap_len", last_gap, 8);
      end
      for (int i = 0; i < hold_after; i++) @(negedge clk);
      if (hold_after > 0 && ch_en) begin
         chk("hold_busy", busy, 1);
         chk("hold_no_retrigger", done_cnt - d0, 1);
      end
      ch_en = 1'b0;
      for (int i = 0; i < 5 && busy; i++) @(negedge clk);
      chk("busy_release", busy, 0);
      chk("done_once", done_cnt - d0, 1);
      chk("frame_count", fq_val.size(), 2);
      if (fq_val.size() == 2) begin
         chk("frame1", fq_val[0], lit_en ? lit_f1 : ef1);
         chk("frame1_len", fq_len[0], 24);
         chk("frame2", fq_val[1], 32'h03);
         chk("frame2_len", fq_len[1], 8);
      end
      chk("status_final", status, m2);
      $display("[TB] txn ch=%0d miso=%02h/%02h status=%02h frame1=%06h frame2=%02h",
               ch, m1, m2, status,
               (fq_val.size() > 0) ? fq_val[0] : 32'h0,
               (fq_val.size() > 1) ? fq_val[1] : 32'h0);
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0, r, drop, chg, hold;
      // Reset state
      #22;
      chk("rst_csn", csn, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status, 8'h00);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Directed: channel 9, MISO status bytes, FREQ boundaries
      run_txn(4'd9,  8'h5A, 8'h42, 0, 0, 0, 1, 24'h184192);
      run_txn(4'd0,  8'hC3, 8'h81, 0, 0, 0, 1, 24'h184165);
      run_txn(4'd15, 8'h0F, 8'hF0, 0, 0, 0, 1, 24'h1841B0);
      // Channel changed mid-transfer, request held 50 cycles after done
      run_txn(4'd9,  8'h33, 8'hCC, 0, 21, 50, 1, 24'h184192);

      // Reset abort at cycle 100 of a transfer
      @(negedge clk);
      channel = 4'd5;
      miso_b1 = 8'hA5;
      miso_b2 = 8'h5A;
      ch_en   = 1'b1;
      repeat (100) @(negedge clk);
      d0 = done_cnt;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("abort_csn", csn, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_busy", busy, 0);
      chk("abort_status", status, 8'h00);
      ch_en = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      run_txn(4'd6, 8'h96, 8'h69, 0, 0, 0, 1, 24'h184183);

      // Randomized transactions
      for (int t = 0; t < 10; t++) begin
         r    = $urandom_range(0, 2);
         drop = (r == 1) ? $urandom_range(5, 250) : 0;
         hold = (r == 2) ? $urandom_range(1, 60) : 0;
         chg  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 200) : 0;
         run_txn(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 drop, chg, hold, 0, 24'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
